// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory-side blocks.
// Holds the arbiter state encoding and line/word typedefs.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_BUSY,
        ARB_D_BUSY,
        ARB_DONE
    } lc3b_arb_state;

    localparam int ARB_STARVE_MAX = 15;

    function automatic logic [3:0] starve_next(input logic [3:0] cnt);
        return (cnt == 4'(ARB_STARVE_MAX)) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Shared by the arbiter and the performance-counter block.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Unified physical-memory arbiter for the I-side and D-side miss paths.
// D has fixed priority; I is forced through after STARVE_LIMIT D grants.
import lc3b_types::*;

module mem_arbiter #(
    parameter int LINE_W       = 128,
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  i_wait_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    lc3b_arb_state     state_q;
    lc3b_arb_state     state_d;
    logic              owner_d_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [3:0]        starve_q;
    logic              busy;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;
    logic              i_done;
    logic              d_done;
    logic              i_wait;

    assign d_req   = d_read | d_write;
    assign busy    = (state_q == ARB_I_BUSY) || (state_q == ARB_D_BUSY);
    assign grant_d = (state_q == ARB_IDLE) && d_req &&
                     (!i_read || (starve_q < LIMIT));
    assign grant_i = (state_q == ARB_IDLE) && !grant_d && i_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_d = ARB_D_BUSY;
                end else if (grant_i) begin
                    state_d = ARB_I_BUSY;
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (pmem_resp) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Request fields are latched at grant so requester changes mid-flight are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            starve_q  <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_d) begin
                owner_d_q <= 1'b1;
                wr_q      <= d_write;
                addr_q    <= d_address;
                wdata_q   <= d_wdata;
                starve_q  <= i_read ? starve_next(starve_q) : 4'd0;
            end else if (grant_i) begin
                owner_d_q <= 1'b0;
                wr_q      <= 1'b0;
                addr_q    <= i_address;
                starve_q  <= 4'd0;
            end
            if (busy && pmem_resp && !wr_q) begin
                if (state_q == ARB_D_BUSY) begin
                    d_rdata <= pmem_rdata;
                end else begin
                    i_rdata <= pmem_rdata;
                end
            end
        end
    end

    always_comb begin
        pmem_read    = busy && !wr_q;
        pmem_write   = busy && wr_q;
        pmem_address = busy ? addr_q : '0;
        pmem_wdata   = (busy && wr_q) ? wdata_q : '0;
        i_resp       = (state_q == ARB_DONE) && !owner_d_q;
        d_resp       = (state_q == ARB_DONE) && owner_d_q;
    end

    assign i_done = i_resp;
    assign d_done = d_resp;
    assign i_wait = i_read && (state_q != ARB_I_BUSY) && !i_resp;

    sat_counter #(.WIDTH(CNT_W)) u_i_grant (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_done),
        .count (i_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_d_grant (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_done),
        .count (d_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_i_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_wait),
        .count (i_wait_cnt)
    );

endmodule
